uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 Parameter DATA_WIDTH, default 8, frame payload width.
REQ-003 Parameter BUSY_TIMEOUT, default 15, maximum cycles to wait for tx_busy rise after issue (legal range 2..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 req  input  NUM_REQ  per-requester transmit request; level, held until granted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_par_en  input  NUM_REQ  per-requester parity enable for its frame.
REQ-009 gnt  output  NUM_REQ  one-hot grant; one-cycle pulse acknowledging capture of request data.
REQ-010 tx_busy  input  1  busy status from the UART transmitter FSM.
REQ-011 tx_data_valid  output  1  one-cycle frame-start strobe to the transmitter.
REQ-012 tx_p_data  output  DATA_WIDTH  registered payload to the transmitter.
REQ-013 tx_par_en  output  1  registered parity enable to the transmitter.
REQ-014 tx_owner  output  $clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-015 timeout_err  output  1  one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT cycles.

Function
REQ-016 The block SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if any req bit is 1, select winner by round-robin starting at index (last_winner+1) mod NUM_REQ, latch its payload into tx_p_data, its parity bit into tx_par_en, its index into tx_owner, update last_winner, go to ISSUE; else stay.
REQ-018 ISSUE (exactly one cycle): gnt[tx_owner]=1 and tx_data_valid=1; next state WAIT_BUSY, timeout counter cleared to 0.
REQ-019 WAIT_BUSY: if tx_busy=1 go to WAIT_DONE; else increment counter; when counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, pulse timeout_err next cycle and go to IDLE.
REQ-020 WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to IDLE.
REQ-021 Latency: req sampled high in IDLE at edge k -> gnt and tx_data_valid high in cycle after edge k; minimum frame-to-frame arbitration gap is one IDLE cycle.
REQ-022 gnt and tx_data_valid SHALL be 0 in every state except ISSUE; gnt SHALL never have more than one bit set.
REQ-023 tx_p_data, tx_par_en, tx_owner SHALL hold their latched values from ISSUE until the next IDLE capture; req_data changes after gnt SHALL not affect them.
REQ-024 Requests changing while not in IDLE SHALL be ignored until return to IDLE; a req dropped before capture is simply not served.
REQ-025 Simultaneous requests: exactly one winner per IDLE decision; every continuously asserting requester SHALL be granted within NUM_REQ frames.
REQ-026 tx_busy already 1 when entering WAIT_BUSY SHALL advance to WAIT_DONE in one cycle (no timeout).
REQ-027 Timeout abandons the frame; last_winner stays updated, so the next grant goes to the following requester.
REQ-028 Out-of-range state encodings SHALL recover to IDLE with outputs at reset values.

Reset
REQ-029 With reset=0 at a rising edge: state=IDLE, last_winner=NUM_REQ-1 (so index 0 has first priority), counter=0, gnt=0, tx_data_valid=0, tx_p_data=0, tx_par_en=0, tx_owner=0, timeout_err=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately at that edge; no further gnt or tx_data_valid until a fresh IDLE decision after reset release.

Verification
REQ-031 After reset, req=4'b0001, data0=8'hA5, par_en0=1 -> gnt=4'b0001 and tx_data_valid=1 one cycle, tx_p_data=8'hA5, tx_par_en=1, tx_owner=0.
REQ-032 req=4'b1111 held, transmitter model busy 11 cycles per frame -> grant order 0,1,2,3,0; no double grants.
REQ-033 req=4'b0101 with last_winner=0 -> requester 2 granted next, then 0.
REQ-034 tx_busy held 0 after issue -> timeout_err pulses exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, state returns IDLE, next grant goes to following requester.
REQ-035 Reset driven low during WAIT_DONE -> all outputs at reset values next cycle; first post-reset grant goes to lowest active index.
REQ-036 Change req_data of owner after gnt -> tx_p_data unchanged through WAIT_DONE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Captures the winner's payload, strobes the transmitter and tracks its busy handshake.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          tx_busy,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_par_en,
  output logic [$clog2(NUM_REQ)-1:0]    tx_owner,
  output logic                          timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         last_winner_q, last_winner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  tx_par_en_q, tx_par_en_d;
  logic [IW-1:0]         tx_owner_q, tx_owner_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IW-1:0]         cand;
  logic [IW-1:0]         win_idx;
  logic                  win_found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan starts one past the previous winner so every requester rotates to top priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IW'(({{(32-IW){1'b0}}, last_winner_q} + off) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    last_winner_d   = last_winner_q;
    cnt_d           = cnt_q;
    gnt_d           = '0;
    tx_data_valid_d = 1'b0;
    timeout_err_d   = 1'b0;
    tx_p_data_d     = tx_p_data_q;
    tx_par_en_d     = tx_par_en_q;
    tx_owner_d      = tx_owner_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          tx_p_data_d      = data_arr[win_idx];
          tx_par_en_d      = req_par_en[win_idx];
          tx_owner_d       = win_idx;
          last_winner_d    = win_idx;
          gnt_d[win_idx]   = 1'b1;
          tx_data_valid_d  = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        last_winner_d = IW'(NUM_REQ - 1);
        cnt_d         = '0;
        tx_p_data_d   = '0;
        tx_par_en_d   = 1'b0;
        tx_owner_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      last_winner_q   <= IW'(NUM_REQ - 1);
      cnt_q           <= '0;
      gnt_q           <= '0;
      tx_data_valid_q <= 1'b0;
      tx_p_data_q     <= '0;
      tx_par_en_q     <= 1'b0;
      tx_owner_q      <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_winner_q   <= last_winner_d;
      cnt_q           <= cnt_d;
      gnt_q           <= gnt_d;
      tx_data_valid_q <= tx_data_valid_d;
      tx_p_data_q     <= tx_p_data_d;
      tx_par_en_q     <= tx_par_en_d;
      tx_owner_q      <= tx_owner_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign gnt           = gnt_q;
  assign tx_data_valid = tx_data_valid_q;
  assign tx_p_data     = tx_p_data_q;
  assign tx_par_en     = tx_par_en_q;
  assign tx_owner      = tx_owner_q;
  assign timeout_err   = timeout_err_q;

endmodule
